// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int          LEN_W    = 16;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        FILL,
        DONE,
        ERR
    } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream receive link plus imem write port, as seen by the loader (master) and its peer (slave).
interface imem_loader_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/imem_word_packer.sv
// Packs four byte transfers little-endian into one 32-bit word; word_valid_o pulses with the 4th byte.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q,  sh_d;

    // NOTE: every variable gets a default at the top of always_comb, otherwise a path that skips it infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clear_i) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (byte_valid_i) begin
            cnt_d = cnt_q + 2'd1;
            sh_d  = {byte_i, sh_q[23:8]};
        end
    end

    // The fourth byte bypasses the register so the word is ready in the same cycle.
    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, sh_q};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> imem words, NOP-filled tail, core held until complete.
// Optional trailing checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    imem_loader_if.master    bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold
);

    loader_state_e     state_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W:0]   widx_q;
    logic              rx_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              busy_q, done_q, error_q, cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
    logic [7:0]        sum_next;
`endif

    logic              rx_fire;
    logic              start_ok;
    logic              word_valid;
    logic [31:0]       word;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W:0]   widx_inc;
    logic              last_word;

    assign rx_fire   = bus.rx_valid && rx_ready_q;
    assign start_ok  = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign len_full  = {bus.rx_data, len_q[7:0]};
    assign widx_inc  = widx_q + (ADDR_W+1)'(1);
    assign last_word = (LEN_W'(widx_inc) == len_q);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign sum_next  = sum_q + bus.rx_data;
`endif

    imem_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start_ok),
        .byte_valid_i (rx_fire && (state_q == DATA)),
        .byte_i       (bus.rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // NOTE: the write-port registers are reset as well, so address/data read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            widx_q     <= '0;
            rx_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q    <= LEN_LO;
                        rx_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        widx_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q      <= '0;
`endif
                    end
                end
                LEN_LO: begin
                    if (rx_fire) begin
                        len_q   <= {8'h00, bus.rx_data};
                        state_q <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (rx_fire) begin
                        len_q <= len_full;
                        if (len_full > LEN_W'(DEPTH)) begin
                            state_q    <= ERR;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else if (len_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_q    <= CHECK;
`else
                            state_q    <= FILL;
                            rx_ready_q <= 1'b0;
                            mem_we_q   <= 1'b1;
                            waddr_q    <= '0;
                            wdata_q    <= NOP_INSN;
`endif
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (rx_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q <= sum_next;
`endif
                        if (word_valid) begin
                            state_q    <= WRITE;
                            rx_ready_q <= 1'b0;
                            mem_we_q   <= 1'b1;
                            waddr_q    <= widx_q[ADDR_W-1:0];
                            wdata_q    <= word;
                        end
                    end
                end
                WRITE: begin
                    widx_q <= widx_inc;
                    if (!last_word) begin
                        state_q    <= DATA;
                        rx_ready_q <= 1'b1;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q    <= CHECK;
                        rx_ready_q <= 1'b1;
`else
                        if (len_q == LEN_W'(DEPTH)) begin
                            state_q    <= DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q  <= FILL;
                            mem_we_q <= 1'b1;
                            waddr_q  <= len_q[ADDR_W-1:0];
                            wdata_q  <= NOP_INSN;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (rx_fire) begin
                        rx_ready_q <= 1'b0;
                        if (sum_next != 8'h00) begin
                            state_q <= ERR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else if (len_q == LEN_W'(DEPTH)) begin
                            state_q    <= DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q  <= FILL;
                            mem_we_q <= 1'b1;
                            waddr_q  <= len_q[ADDR_W-1:0];
                            wdata_q  <= NOP_INSN;
                        end
                    end
                end
`endif
                FILL: begin
                    // The write at waddr_q happens this cycle; stop once the top word is covered.
                    if (waddr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        mem_we_q <= 1'b1;
                        waddr_q  <= waddr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign cpu_hold      = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, reset/restart sequences, randomized frames vs a frame model.
module tb_imem_loader;

    localparam int          DEPTH  = 16;
    localparam int          ADDR_W = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit          CKSUM  = 1'b1;
`else
    localparam bit          CKSUM  = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, error, cpu_hold;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]        frame_q[$];
    logic [ADDR_W-1:0] got_wa[$];
    logic [31:0]       got_wd[$];
    logic [ADDR_W-1:0] exp_wa[$];
    logic [31:0]       exp_wd[$];
    bit                exp_done, exp_err;

    typedef struct {
        int               n;
        logic [0:11][7:0] b;
        bit               stall;
        bit               restart;
        bit               exp_done;
        bit               exp_err;
        int               exp_writes;
        logic [31:0]      exp_w0;
        logic [31:0]      exp_w1;
    } vec_t;

    vec_t vecs[$];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            got_wa.push_back(bus.mem_waddr);
            got_wd.push_back(bus.mem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected write sequence and final status derived directly from the frame format.
    function automatic void model();
        int n;
        int sum;
        logic [31:0] w;
        exp_wa.delete();
        exp_wd.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'(frame_q[0]) + 256 * int'(frame_q[1]);
        if (n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        sum = 0;
        for (int k = 0; k < n; k++) begin
            w = 0;
            for (int j = 0; j < 4; j++) begin
                w   = w + (32'(frame_q[2 + 4*k + j]) << (8*j));
                sum = sum + int'(frame_q[2 + 4*k + j]);
            end
            exp_wa.push_back(ADDR_W'(k));
            exp_wd.push_back(w);
        end
        if (CKSUM && ((sum + int'(frame_q[2 + 4*n])) % 256 != 0)) begin
            exp_err = 1'b1;
            return;
        end
        for (int a = n; a < DEPTH; a++) begin
            exp_wa.push_back(ADDR_W'(a));
            exp_wd.push_back(NOP);
        end
        exp_done = 1'b1;
    endfunction

    task automatic run_frame(input bit stall, input bit restart, input int stop_after);
        int i   = 0;
        int cyc = 0;
        bit rdy;
        got_wa.delete();
        got_wd.delete();
        @(negedge clk);
        // The first byte is already offered alongside start and must not be consumed.
        start        = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = frame_q[0];
        @(negedge clk);
        start = 1'b0;
        while (i < frame_q.size() && i != stop_after && cyc < 4000 && busy) begin
            rdy   = bus.rx_ready;
            start = restart && (i == 6);
            if (stall && cyc[0]) begin
                bus.rx_valid = 1'b0;
            end else begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = frame_q[i];
            end
            @(posedge clk);
            if (bus.rx_valid && rdy) i++;
            @(negedge clk);
            cyc++;
        end
        bus.rx_valid = 1'b0;
        start        = 1'b0;
        if (stop_after < 0) begin
            cyc = 0;
            while (busy && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("busy_timeout", busy, 1'b0);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic compare_model(input string tag);
        model();
        check({tag, ".nwrites"}, got_wa.size(), exp_wa.size());
        for (int k = 0; k < exp_wa.size(); k++) begin
            if (k < got_wa.size()) begin
                check($sformatf("%s.waddr[%0d]", tag, k), got_wa[k], exp_wa[k]);
                check($sformatf("%s.wdata[%0d]", tag, k), got_wd[k], exp_wd[k]);
            end
        end
        check({tag, ".done"},     done,     exp_done);
        check({tag, ".error"},    error,    exp_err);
        check({tag, ".cpu_hold"}, cpu_hold, !exp_done);
        check({tag, ".busy"},     busy,     1'b0);
        check({tag, ".rx_ready"}, bus.rx_ready, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".rx_ready"},  bus.rx_ready,  1'b0);
        check({tag, ".mem_we"},    bus.mem_we,    1'b0);
        check({tag, ".mem_waddr"}, bus.mem_waddr, '0);
        check({tag, ".mem_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, ".busy"},      busy,          1'b0);
        check({tag, ".done"},      done,          1'b0);
        check({tag, ".error"},     error,         1'b0);
        check({tag, ".cpu_hold"},  cpu_hold,      1'b1);
    endtask

    function automatic void load_frame(input vec_t v);
        frame_q.delete();
        for (int k = 0; k < v.n; k++) frame_q.push_back(v.b[k]);
    endfunction

    initial begin
        vec_t v;
        logic [31:0] a0, a1;
        int n, sum;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Vector table: base image, oversize length, checksum failure, stalled/restarted image, empty, single word.
        v = '{n: CKSUM ? 11 : 10,
              b: {8'h02, 8'h00, 8'hB7, 8'h50, 8'h34, 8'h12, 8'h17, 8'h01, 8'h00, 8'h01, 8'h9A, 8'h00},
              stall: 0, restart: 0, exp_done: 1, exp_err: 0, exp_writes: 16,
              exp_w0: 32'h1234_50B7, exp_w1: 32'h0100_0117};
        vecs.push_back(v);
        v = '{n: 2, b: {8'h11, 8'h00, 80'h0}, stall: 0, restart: 0, exp_done: 0, exp_err: 1,
              exp_writes: 0, exp_w0: 32'h0, exp_w1: 32'h0};
        vecs.push_back(v);
        if (CKSUM) begin
            v = '{n: 11,
                  b: {8'h02, 8'h00, 8'hB7, 8'h50, 8'h34, 8'h12, 8'h17, 8'h01, 8'h00, 8'h01, 8'h9B, 8'h00},
                  stall: 0, restart: 0, exp_done: 0, exp_err: 1, exp_writes: 2,
                  exp_w0: 32'h1234_50B7, exp_w1: 32'h0100_0117};
            vecs.push_back(v);
        end
        v = '{n: CKSUM ? 11 : 10,
              b: {8'h02, 8'h00, 8'hB7, 8'h50, 8'h34, 8'h12, 8'h17, 8'h01, 8'h00, 8'h01, 8'h9A, 8'h00},
              stall: 1, restart: 1, exp_done: 1, exp_err: 0, exp_writes: 16,
              exp_w0: 32'h1234_50B7, exp_w1: 32'h0100_0117};
        vecs.push_back(v);
        v = '{n: CKSUM ? 3 : 2, b: {96'h0}, stall: 0, restart: 0, exp_done: 1, exp_err: 0,
              exp_writes: 16, exp_w0: NOP, exp_w1: NOP};
        vecs.push_back(v);
        v = '{n: CKSUM ? 7 : 6,
              b: {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC8, 40'h0},
              stall: 1, restart: 0, exp_done: 1, exp_err: 0, exp_writes: 16,
              exp_w0: 32'hDEAD_BEEF, exp_w1: NOP};
        vecs.push_back(v);

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < vecs.size(); t++) begin
            load_frame(vecs[t]);
            run_frame(vecs[t].stall, vecs[t].restart, -1);
            a0 = (got_wd.size() > 0) ? got_wd[0] : 32'hxxxx_xxxx;
            a1 = (got_wd.size() > 1) ? got_wd[1] : 32'hxxxx_xxxx;
            check($sformatf("vec%0d.nwrites", t), got_wd.size(), vecs[t].exp_writes);
            if (vecs[t].exp_writes > 0) check($sformatf("vec%0d.w0", t), a0, vecs[t].exp_w0);
            if (vecs[t].exp_writes > 1) check($sformatf("vec%0d.w1", t), a1, vecs[t].exp_w1);
            check($sformatf("vec%0d.done", t),     done,     vecs[t].exp_done);
            check($sformatf("vec%0d.error", t),    error,    vecs[t].exp_err);
            check($sformatf("vec%0d.cpu_hold", t), cpu_hold, !vecs[t].exp_done);
            compare_model($sformatf("vec%0d", t));
        end

        // Reset after two data bytes, then a fresh load of the base image.
        load_frame(vecs[0]);
        run_frame(1'b0, 1'b0, 4);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(1'b0, 1'b0, -1);
        compare_model("after_reset");

        // Randomized frames, including full-depth images, oversize lengths and corrupted checksums.
        for (int r = 0; r < 12; r++) begin
            int kind;
            kind = $urandom_range(0, 9);
            frame_q.delete();
            if (kind == 1) begin
                n = $urandom_range(DEPTH + 1, 4000);
                frame_q.push_back(8'(n));
                frame_q.push_back(8'(n >> 8));
            end else begin
                n = (kind == 0 || r == 0) ? DEPTH : $urandom_range(0, DEPTH);
                frame_q.push_back(8'(n));
                frame_q.push_back(8'(n >> 8));
                sum = 0;
                for (int k = 0; k < 4 * n; k++) begin
                    frame_q.push_back(8'($urandom));
                    sum = sum + int'(frame_q[frame_q.size() - 1]);
                end
                if (CKSUM) frame_q.push_back(8'(256 - (sum % 256)) + 8'(($urandom_range(0, 3) == 0) ? 1 : 0));
            end
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            compare_model($sformatf("rand%0d", r));
        end

        // Offered bytes outside a load are never taken and cause no writes.
        got_wa.delete();
        got_wd.delete();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        repeat (4) @(negedge clk);
        bus.rx_valid = 1'b0;
        check("idle.nwrites",  got_wa.size(), 0);
        check("idle.busy",     busy,          1'b0);
        check("idle.rx_ready", bus.rx_ready,  1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
